// File: rtl/dmem_resp_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
// master = requester (MEM stage), slave = dmem_resp.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Fixed-latency data memory responder: one outstanding request, byte-lane
// stores, misaligned or out-of-range accesses answered with resp_err.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request latched, latency down-counter running
// RESP  | response presented, held until resp_ready
module dmem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          fault;
  logic [AW-1:0] idx;
  logic          commit;

  assign fault  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign idx    = addr_q[AW+1:2];
  assign commit = (state == WAIT) && (cnt == 4'd0);

  // Storage is deliberately not reset; a reset in WAIT drops state to IDLE
  // asynchronously, so commit can never fire for the discarded store.
  always_ff @(posedge clk) begin
    if (commit && we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            be_q        <= bus.req_be;
            cnt         <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            err_q        <= fault;
            // Loads read the pre-edge word; a store never overlaps a load.
            rdata_q      <= (fault || we_q) ? 32'd0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances (LATENCY 2, 1, 15) share the
// request bus; sel picks which one sees req_valid and whose outputs are checked.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        resp_ready = 1'b1;
  logic [1:0]  sel = 2'd0;

  int total = 0;
  int bad   = 0;

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_rdata;
  logic        obs_err;

  always #5 clk = ~clk;

  dmem_resp_if bus2 ();
  dmem_resp_if bus1 ();
  dmem_resp_if bus15 ();

  assign bus2.req_valid   = req_valid & (sel == 2'd0);
  assign bus2.req_we      = req_we;
  assign bus2.req_addr    = req_addr;
  assign bus2.req_wdata   = req_wdata;
  assign bus2.req_be      = req_be;
  assign bus2.resp_ready  = resp_ready;

  assign bus1.req_valid   = req_valid & (sel == 2'd1);
  assign bus1.req_we      = req_we;
  assign bus1.req_addr    = req_addr;
  assign bus1.req_wdata   = req_wdata;
  assign bus1.req_be      = req_be;
  assign bus1.resp_ready  = resp_ready;

  assign bus15.req_valid  = req_valid & (sel == 2'd2);
  assign bus15.req_we     = req_we;
  assign bus15.req_addr   = req_addr;
  assign bus15.req_wdata  = req_wdata;
  assign bus15.req_be     = req_be;
  assign bus15.resp_ready = resp_ready;

  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(2))  u_lat2  (.clk(clk), .rst(rst), .bus(bus2));
  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(1))  u_lat1  (.clk(clk), .rst(rst), .bus(bus1));
  dmem_resp #(.DEPTH_WORDS(256), .LATENCY(15)) u_lat15 (.clk(clk), .rst(rst), .bus(bus15));

  always_comb begin
    obs_ready = bus2.req_ready;
    obs_valid = bus2.resp_valid;
    obs_rdata = bus2.resp_rdata;
    obs_err   = bus2.resp_err;
    if (sel == 2'd1) begin
      obs_ready = bus1.req_ready;
      obs_valid = bus1.resp_valid;
      obs_rdata = bus1.resp_rdata;
      obs_err   = bus1.resp_err;
    end else if (sel == 2'd2) begin
      obs_ready = bus15.req_ready;
      obs_valid = bus15.resp_valid;
      obs_rdata = bus15.resp_rdata;
      obs_err   = bus15.resp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; after acceptance the request inputs are
  // scrambled so a design that fails to latch them returns wrong data.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    lat = (sel == 2'd0) ? 2 : (sel == 2'd1) ? 1 : 15;
    resp_ready = (hold == 0);
    @(negedge clk);
    n = 0;
    while (!obs_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 32'(obs_ready), 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h44;
    req_wdata = ~wdata;
    req_be    = ~be;
    chk({tag, "_acc"}, 32'(obs_ready), 32'd0);
    n = 0;
    while (!obs_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, obs_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(obs_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, 32'(obs_valid), 32'd1);
      chk({tag, "_hold_d"}, obs_rdata, exp_rdata);
      chk({tag, "_hold_r"}, 32'(obs_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_v"}, 32'(obs_valid), 32'd0);
    chk({tag, "_done_r"}, 32'(obs_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_rdata", obs_rdata, 32'd0);
    chk("rst_err", 32'(obs_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready0", 32'(obs_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready1", 32'(obs_ready), 32'd1);

    xfer("init20",  1'b1, 32'h20,  32'h0000_0000, 4'hF, 0, 32'h0, 1'b0);
    xfer("st10",    1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xfer("ld10",    1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    xfer("st10b0",  1'b1, 32'h10,  32'h0000_00AA, 4'b0001, 0, 32'h0, 1'b0);
    xfer("ld10b0",  1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0);
    xfer("st_nobe", 1'b1, 32'h10,  32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b0);
    xfer("ld_nobe", 1'b0, 32'h10,  32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0);
    xfer("st10b3",  1'b1, 32'h10,  32'h5500_0000, 4'b1000, 0, 32'h0, 1'b0);
    xfer("ld10b3",  1'b0, 32'h10,  32'h0,         4'h0, 0, 32'h55AD_BEAA, 1'b0);
    xfer("st0",     1'b1, 32'h0,   32'h1122_3344, 4'hF, 0, 32'h0, 1'b0);
    xfer("ld_mis",  1'b0, 32'h13,  32'h0,         4'h0, 0, 32'h0, 1'b1);
    xfer("ld_oor",  1'b0, 32'h400, 32'h0,         4'h0, 0, 32'h0, 1'b1);
    xfer("st_oor",  1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
    xfer("ld0",     1'b0, 32'h0,   32'h0,         4'h0, 0, 32'h1122_3344, 1'b0);
    xfer("st_top",  1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    xfer("ld_top",  1'b0, 32'h3FC, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0);
    xfer("hold",    1'b0, 32'h10,  32'h0,         4'h0, 5, 32'h55AD_BEAA, 1'b0);

    // Reset while a store sits in WAIT: outputs clear at once, store dropped.
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wr_acc", 32'(obs_ready), 32'd0);
    @(negedge clk);
    chk("pre_rst_rdata", obs_rdata, 32'h55AD_BEAA);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(obs_valid), 32'd0);
    chk("mid_rst_rdata", obs_rdata, 32'd0);
    chk("mid_rst_err", 32'(obs_err), 32'd0);
    chk("mid_rst_ready", 32'(obs_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(obs_ready), 32'd1);
    xfer("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0);

    sel = 2'd1;
    xfer("l1_st", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xfer("l1_ld", 1'b0, 32'h10, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    sel = 2'd2;
    xfer("l15_st", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    xfer("l15_ld", 1'b0, 32'h10, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
